ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Shares one single-port synchronous RAM among three requesters: the video fetch path (read-only), the 6502 CPU (read/write) and the PS/2 keyboard scancode writer (write-only). Each requester uses a req/gnt handshake. Read data is returned in order with a one-cycle valid pulse. The block also drives a wait flag that holds the CPU while its access is pending.

Parameters:
AW, 16, address width
DW, 8, data width
RD_LAT, 1, RAM read latency in cycles: mem_dbi is valid RD_LAT edges after the edge that samples the mem_* command
VID_MAX, 4, max consecutive video transfers while cpu or kbd is pending (>=1)

Ports:
CLOCK_50  in  1  sole clock; all state updates on posedge
res  in  1  synchronous reset, active low
vid_req  in  1  video read request (level)
vid_adr  in  AW  video read address
vid_gnt  out  1  video transfer accepted this cycle
vid_rdata  out  DW  video read data (registered, holds value)
vid_rvalid  out  1  one-cycle pulse, vid_rdata valid
cpu_req  in  1  CPU request (level)
cpu_we  in  1  1 = write, 0 = read
cpu_adr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU transfer accepted this cycle
cpu_rdata  out  DW  CPU read data (registered, holds value)
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_wait  out  1  cpu_req & !cpu_gnt (combinational); CPU rdy = !cpu_wait
kbd_req  in  1  keyboard write request (level)
kbd_adr  in  AW  keyboard write address
kbd_wdata  in  DW  keyboard write data
kbd_gnt  out  1  keyboard transfer accepted this cycle
mem_en  out  1  RAM command valid (registered)
mem_we  out  1  RAM write enable (registered)
mem_adr  out  AW  RAM address (registered)
mem_dbo  out  DW  RAM write data (registered)
mem_dbi  in  DW  RAM read data

Behaviour:
- Transfer: occurs at a posedge where X_req & X_gnt. The gnt signals are combinational from req inputs and registered state. At most one gnt is high per cycle. All gnt are 0 while res=0.
- Requester inputs (adr, we, wdata) must be stable while req is high. req may stay high after a transfer, which requests the next access. Back-to-back transfers to the same requester are allowed.
- Arbitration order:
  (1) vid wins if vid_req and (vid_run < VID_MAX or !(cpu_req|kbd_req)).
  (2) Otherwise, if both cpu_req and kbd_req are high, the one not granted last (rr pointer) wins.
  (3) Otherwise, whichever of cpu/kbd requests wins.
  (4) Otherwise no grant.
- vid_run (saturating counter, width ceil(log2(VID_MAX+1))):
  - +1 on a vid transfer while cpu_req|kbd_req.
  - Clears on any cpu/kbd transfer, and in any cycle with !(cpu_req|kbd_req).
  - Reset 0.
- rr pointer: updates to the granted requester on cpu/kbd transfers. Reset value = kbd, so the CPU wins the first tie.
- Command: the transfer edge registers mem_en=1, mem_adr, mem_we (vid 0, kbd 1, cpu cpu_we), mem_dbo (kbd_wdata/cpu_wdata, else 0). With no transfer, mem_en=0 and mem_we=0; mem_adr and mem_dbo hold their values.
- Read return:
  - A tag shift register of depth RD_LAT+1 carries {valid, owner} for reads only; writes produce no return.
  - RD_LAT+1 edges after the transfer edge, mem_dbi is registered into the owner's rdata and the owner's rvalid is high for exactly the following cycle.
  - RD_LAT=1 gives rvalid 2 cycles after the transfer edge. One read return per cycle at full throughput.
- Ordering: strictly in grant order. A write transferred before a read to the same address is visible to that read. There is no bypass.
- Reset (res=0 at an edge): clears mem_en, mem_we, mem_adr, mem_dbo, both rdata, all rvalid, tags, vid_run, and rr (to kbd). In-flight reads are discarded: no rvalid follows a reset edge. Reset may assert mid-operation. First grant is possible in the cycle after the first edge with res=1.
- cpu_wait is 0 while res=0.

Test Plan:
- Reset: all req=1, res=0 for 3 cycles -> all gnt=0, mem_en=0, rvalid=0, cpu_wait=0. res=1 -> vid_gnt=1 the next cycle.
- Lone CPU read: cpu_req=1, cpu_we=0, cpu_adr=16'h1234, RAM[1234]=8'hA5 -> cpu_gnt=1 same cycle; next cycle mem_en=1, mem_we=0, mem_adr=1234; cpu_rvalid=1 with cpu_rdata=A5 two cycles after the transfer edge.
- CPU/kbd contention, both held high, writes -> grants alternate cpu, kbd, cpu, kbd. cpu_wait=1 in each kbd cycle.
- Video pressure, VID_MAX=4: vid_req and cpu_req held high -> grant pattern vid x4, cpu, vid x4, cpu. Drop cpu_req -> vid granted every cycle.
- Reset mid-read: CPU read transferred, res=0 at the next edge -> no cpu_rvalid for 5 cycles; mem_en=0.
- Ordering: kbd writes 8'h3C to 16'h0400, then CPU reads 16'h0400 back-to-back -> cpu_rdata=3C. The interleaved vid read of 16'h0400 returns 3C on vid_rvalid if granted after the write.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM signal bundle for ram_arbiter
interface ram_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          vid_req;
   logic [AW-1:0] vid_adr;
   logic          vid_gnt;
   logic [DW-1:0] vid_rdata;
   logic          vid_rvalid;

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_adr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic          cpu_wait;

   logic          kbd_req;
   logic [AW-1:0] kbd_adr;
   logic [DW-1:0] kbd_wdata;
   logic          kbd_gnt;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_dbo;
   logic [DW-1:0] mem_dbi;

   modport slave (
      input  vid_req, vid_adr,
      input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
      input  kbd_req, kbd_adr, kbd_wdata,
      input  mem_dbi,
      output vid_gnt, vid_rdata, vid_rvalid,
      output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_wait,
      output kbd_gnt,
      output mem_en, mem_we, mem_adr, mem_dbo
   );

   modport master (
      output vid_req, vid_adr,
      output cpu_req, cpu_we, cpu_adr, cpu_wdata,
      output kbd_req, kbd_adr, kbd_wdata,
      output mem_dbi,
      input  vid_gnt, vid_rdata, vid_rvalid,
      input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_wait,
      input  kbd_gnt,
      input  mem_en, mem_we, mem_adr, mem_dbo
   );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter for video, CPU and keyboard requesters
module ram_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int RD_LAT  = 1,
   parameter int VID_MAX = 4
) (
   input  logic        CLOCK_50,
   input  logic        res,
   ram_arbiter_if.slave bus
);
   localparam int RW = $clog2(VID_MAX + 1);

   logic          r_run;
   logic [RW-1:0] r_vid_run;
   logic          r_rr_kbd;
   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_adr;
   logic [DW-1:0] r_mem_dbo;
   logic [DW-1:0] r_vid_rdata;
   logic [DW-1:0] r_cpu_rdata;
   logic          r_vid_rvalid;
   logic          r_cpu_rvalid;
   logic [RD_LAT:0] r_tag_v;
   logic [RD_LAT:0] r_tag_cpu;

   logic w_any_ck;
   logic w_vid_win;
   logic w_vid_gnt;
   logic w_cpu_gnt;
   logic w_kbd_gnt;
   logic w_xfer;

   // r_run holds grants off until the first edge that sees res high
   always_comb begin
      w_any_ck  = bus.cpu_req | bus.kbd_req;
      w_vid_win = bus.vid_req & ((r_vid_run < RW'(VID_MAX)) | ~w_any_ck);
      w_vid_gnt = r_run & res & w_vid_win;
      w_cpu_gnt = r_run & res & ~w_vid_win & bus.cpu_req & (~bus.kbd_req | r_rr_kbd);
      w_kbd_gnt = r_run & res & ~w_vid_win & bus.kbd_req & (~bus.cpu_req | ~r_rr_kbd);
      w_xfer    = w_vid_gnt | w_cpu_gnt | w_kbd_gnt;
   end

   assign bus.vid_gnt    = w_vid_gnt;
   assign bus.cpu_gnt    = w_cpu_gnt;
   assign bus.kbd_gnt    = w_kbd_gnt;
   assign bus.cpu_wait   = res & bus.cpu_req & ~w_cpu_gnt;
   assign bus.mem_en     = r_mem_en;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_adr    = r_mem_adr;
   assign bus.mem_dbo    = r_mem_dbo;
   assign bus.vid_rdata  = r_vid_rdata;
   assign bus.cpu_rdata  = r_cpu_rdata;
   assign bus.vid_rvalid = r_vid_rvalid;
   assign bus.cpu_rvalid = r_cpu_rvalid;

   always_ff @(posedge CLOCK_50) begin
      if (!res) begin
         r_run        <= 1'b0;
         r_vid_run    <= '0;
         r_rr_kbd     <= 1'b1;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_adr    <= '0;
         r_mem_dbo    <= '0;
         r_vid_rdata  <= '0;
         r_cpu_rdata  <= '0;
         r_vid_rvalid <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_tag_v      <= '0;
         r_tag_cpu    <= '0;
      end else begin
         r_run    <= 1'b1;
         r_mem_en <= w_xfer;
         r_mem_we <= w_kbd_gnt | (w_cpu_gnt & bus.cpu_we);

         if (w_vid_gnt) begin
            r_mem_adr <= bus.vid_adr;
            r_mem_dbo <= '0;
         end else if (w_cpu_gnt) begin
            r_mem_adr <= bus.cpu_adr;
            r_mem_dbo <= bus.cpu_wdata;
         end else if (w_kbd_gnt) begin
            r_mem_adr <= bus.kbd_adr;
            r_mem_dbo <= bus.kbd_wdata;
         end

         if (w_cpu_gnt | w_kbd_gnt | ~w_any_ck)
            r_vid_run <= '0;
         else if (w_vid_gnt && (r_vid_run < RW'(VID_MAX)))
            r_vid_run <= r_vid_run + 1'b1;

         if (w_cpu_gnt)
            r_rr_kbd <= 1'b0;
         else if (w_kbd_gnt)
            r_rr_kbd <= 1'b1;

         // only reads enter the return pipe; the last stage lines up with mem_dbi
         r_tag_v[0]   <= w_vid_gnt | (w_cpu_gnt & ~bus.cpu_we);
         r_tag_cpu[0] <= w_cpu_gnt;
         for (int i = 1; i <= RD_LAT; i++) begin
            r_tag_v[i]   <= r_tag_v[i-1];
            r_tag_cpu[i] <= r_tag_cpu[i-1];
         end

         r_vid_rvalid <= r_tag_v[RD_LAT] & ~r_tag_cpu[RD_LAT];
         r_cpu_rvalid <= r_tag_v[RD_LAT] & r_tag_cpu[RD_LAT];
         if (r_tag_v[RD_LAT] & ~r_tag_cpu[RD_LAT])
            r_vid_rdata <= bus.mem_dbi;
         if (r_tag_v[RD_LAT] & r_tag_cpu[RD_LAT])
            r_cpu_rdata <= bus.mem_dbi;
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter
`timescale 1ns/1ps
module tb_ram_arbiter;
   logic CLOCK_50 = 1'b0;
   logic res      = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [7:0] vid_q[$];
   logic [7:0] cpu_q[$];

   ram_arbiter_if #(.AW(16), .DW(8)) bus ();

   ram_arbiter #(.AW(16), .DW(8), .RD_LAT(1), .VID_MAX(4)) dut (
      .CLOCK_50 (CLOCK_50),
      .res      (res),
      .bus      (bus.slave)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // RAM model: registered read, preloaded on the first edge
   logic [7:0] ram [0:65535];
   logic [7:0] r_q = 8'h00;
   logic       r_loaded = 1'b0;
   always @(posedge CLOCK_50) begin
      if (!r_loaded) begin
         for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
         ram[16'h1234] <= 8'hA5;
         ram[16'h2000] <= 8'h5A;
         r_loaded <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_adr] <= bus.mem_dbo;
         else            r_q <= ram[bus.mem_adr];
      end
   end
   assign bus.mem_dbi = r_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic mid();
      @(negedge CLOCK_50);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic monitor();
      forever begin
         @(negedge CLOCK_50);
         if (bus.vid_rvalid === 1'b1) begin
            if (vid_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL vid_rvalid_unexpected: got rdata %h expected no return", bus.vid_rdata);
            end else chk("vid_rdata", {24'h0, bus.vid_rdata}, {24'h0, vid_q.pop_front()});
         end
         if (bus.cpu_rvalid === 1'b1) begin
            if (cpu_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL cpu_rvalid_unexpected: got rdata %h expected no return", bus.cpu_rdata);
            end else chk("cpu_rdata", {24'h0, bus.cpu_rdata}, {24'h0, cpu_q.pop_front()});
         end
      end
   endtask

   initial begin
      bus.vid_req = 1'b1;  bus.vid_adr = 16'h2000;
      bus.cpu_req = 1'b1;  bus.cpu_we  = 1'b0; bus.cpu_adr = 16'h1234; bus.cpu_wdata = 8'h00;
      bus.kbd_req = 1'b1;  bus.kbd_adr = 16'h0000; bus.kbd_wdata = 8'h00;
      fork monitor(); join_none

      // reset with every request raised
      repeat (3) begin
         mid();
         chk("rst_vid_gnt", bus.vid_gnt, 0);
         chk("rst_cpu_gnt", bus.cpu_gnt, 0);
         chk("rst_kbd_gnt", bus.kbd_gnt, 0);
         chk("rst_mem_en", bus.mem_en, 0);
         chk("rst_vid_rvalid", bus.vid_rvalid, 0);
         chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
         chk("rst_cpu_wait", bus.cpu_wait, 0);
         cyc();
      end
      res = 1'b1;
      mid();
      chk("first_cycle_vid_gnt", bus.vid_gnt, 0);
      cyc();
      mid();
      chk("post_rst_vid_gnt", bus.vid_gnt, 1);
      chk("post_rst_cpu_gnt", bus.cpu_gnt, 0);
      chk("post_rst_kbd_gnt", bus.kbd_gnt, 0);
      chk("post_rst_cpu_wait", bus.cpu_wait, 1);
      vid_q.push_back(8'h5A);
      cyc();
      bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.kbd_req = 1'b0;
      idle(4);

      // cpu/kbd write contention: cpu takes the first tie after reset
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 16'h0100; bus.cpu_wdata = 8'h77;
      bus.kbd_req = 1'b1; bus.kbd_adr = 16'h0101; bus.kbd_wdata = 8'h88;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("rr_cpu_gnt", bus.cpu_gnt, (i % 2 == 0));
         chk("rr_kbd_gnt", bus.kbd_gnt, (i % 2 == 1));
         chk("rr_cpu_wait", bus.cpu_wait, (i % 2 == 1));
         if (i > 0) begin
            chk("rr_mem_we", bus.mem_we, 1);
            chk("rr_mem_dbo", bus.mem_dbo, (i % 2 == 1) ? 8'h77 : 8'h88);
         end
         cyc();
      end
      bus.cpu_req = 1'b0; bus.kbd_req = 1'b0; bus.cpu_we = 1'b0;
      idle(2);

      // lone cpu read with latency check
      bus.cpu_req = 1'b1; bus.cpu_adr = 16'h1234;
      mid();
      chk("rd_cpu_gnt", bus.cpu_gnt, 1);
      chk("rd_cpu_wait", bus.cpu_wait, 0);
      cpu_q.push_back(8'hA5);
      cyc();
      bus.cpu_req = 1'b0;
      mid();
      chk("rd_mem_en", bus.mem_en, 1);
      chk("rd_mem_we", bus.mem_we, 0);
      chk("rd_mem_adr", bus.mem_adr, 16'h1234);
      chk("rd_rvalid_early0", bus.cpu_rvalid, 0);
      cyc();
      mid();
      chk("rd_rvalid_early1", bus.cpu_rvalid, 0);
      chk("rd_mem_en_idle", bus.mem_en, 0);
      cyc();
      mid();
      chk("rd_rvalid_on_time", bus.cpu_rvalid, 1);
      cyc();
      mid();
      chk("rd_rvalid_pulse", bus.cpu_rvalid, 0);
      idle(2);

      // video pressure: four vid grants then one cpu grant
      bus.vid_req = 1'b1; bus.vid_adr = 16'h2000;
      bus.cpu_req = 1'b1; bus.cpu_adr = 16'h1234;
      for (int i = 0; i < 10; i++) begin
         mid();
         chk("vp_vid_gnt", bus.vid_gnt, (i % 5 != 4));
         chk("vp_cpu_gnt", bus.cpu_gnt, (i % 5 == 4));
         if (i % 5 == 4) cpu_q.push_back(8'hA5);
         else            vid_q.push_back(8'h5A);
         cyc();
      end
      bus.cpu_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mid();
         chk("vp_solo_vid_gnt", bus.vid_gnt, 1);
         vid_q.push_back(8'h5A);
         cyc();
      end
      bus.vid_req = 1'b0;
      idle(4);

      // reset while a cpu read is in flight
      bus.cpu_req = 1'b1; bus.cpu_adr = 16'h1234;
      mid();
      chk("mr_cpu_gnt", bus.cpu_gnt, 1);
      cyc();
      bus.cpu_req = 1'b0;
      res = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         mid();
         chk("mr_cpu_rvalid", bus.cpu_rvalid, 0);
         chk("mr_mem_en", bus.mem_en, 0);
      end
      cyc();
      res = 1'b1;
      idle(2);

      // write then reads of the same address, video interleaved
      bus.kbd_req = 1'b1; bus.kbd_adr = 16'h0400; bus.kbd_wdata = 8'h3C;
      mid();
      chk("ord_kbd_gnt", bus.kbd_gnt, 1);
      cyc();
      bus.kbd_req = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 16'h0400;
      bus.vid_req = 1'b1; bus.vid_adr = 16'h0400;
      mid();
      chk("ord_vid_gnt", bus.vid_gnt, 1);
      chk("ord_cpu_held", bus.cpu_gnt, 0);
      vid_q.push_back(8'h3C);
      cyc();
      bus.vid_req = 1'b0;
      mid();
      chk("ord_cpu_gnt", bus.cpu_gnt, 1);
      cpu_q.push_back(8'h3C);
      cyc();
      bus.cpu_req = 1'b0;
      idle(6);

      chk("vid_q_drained", vid_q.size(), 0);
      chk("cpu_q_drained", cpu_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
